// File: rtl/shared_bus_resolver.sv
// Registered resolver for a shared pulled-up bus.
// The arbitrated path uses a round-robin grant that is held for a whole burst.
// Forced drivers bypass the arbiter and combine by wired-AND or wired-OR.
// An idle bus reads all-ones. Disagreeing forced drivers are flagged and counted.
module shared_bus_resolver #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N       = 4,
    parameter int unsigned RESOLVE = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       last,
    input  logic [N*WIDTH-1:0] wdata,
    input  logic [N-1:0]       force_en,
    output logic [N-1:0]       grant,
    output logic [WIDTH-1:0]   bus,
    output logic               bus_driven,
    output logic               contention,
    output logic [CNT_W-1:0]   conflict_cnt
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } state_e;

    state_e              state_q;
    logic [N-1:0]        grant_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       last_owner_q;

    logic [WIDTH-1:0]    bus_q, bus_d;
    logic                bus_driven_q, bus_driven_d;
    logic                contention_q, contention_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                any_force;
    logic [WIDTH-1:0]    and_val, or_val, resolved;
    logic [WIDTH-1:0]    owner_data;
    logic                owner_last, owner_req;
    logic                found;
    logic [IW-1:0]       winner;
    logic [N-1:0]        winner_oh;
    logic                acquire, release_own;

    assign any_force = |force_en;

    // Fold the forced channels both ways; they all agree exactly when AND equals OR.
    always_comb begin
        and_val = '1;
        or_val  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (force_en[i]) begin
                and_val = and_val & wdata[i*WIDTH +: WIDTH];
                or_val  = or_val  | wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign resolved     = (RESOLVE != 0) ? or_val : and_val;
    // With no forced channel AND/OR differ trivially, so gate with any_force.
    assign contention_d = any_force && (and_val != or_val);

    // Select data and burst controls of the current owner.
    always_comb begin
        owner_data = '1;
        owner_last = 1'b0;
        owner_req  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (owner_q == IW'(i)) begin
                owner_data = wdata[i*WIDTH +: WIDTH];
                owner_last = last[i];
                owner_req  = req[i];
            end
        end
    end

    // Round-robin pick: first requester scanning upward from last_owner+1 with wrap.
    always_comb begin
        int idx;
        found     = 1'b0;
        winner    = '0;
        winner_oh = '0;
        idx       = 0;
        for (int off = 1; off <= int'(N); off++) begin
            idx = int'(last_owner_q) + off;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (!found && req[idx]) begin
                found          = 1'b1;
                winner         = IW'(idx);
                winner_oh[idx] = 1'b1;
            end
        end
    end

    // Forced drivers freeze the arbiter entirely.
    assign acquire     = (state_q == StIdle) && !any_force && found;
    assign release_own = (state_q == StOwn) && !any_force && (owner_last || !owner_req);

    // Arbiter FSM with registered one-hot grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(N - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (acquire) begin
                        state_q <= StOwn;
                        grant_q <= winner_oh;
                        owner_q <= winner;
                    end
                end
                StOwn: begin
                    if (release_own) begin
                        state_q      <= StIdle;
                        grant_q      <= '0;
                        last_owner_q <= owner_q;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Next bus value: forced drivers first, then the owner, else the pull-up.
    always_comb begin
        bus_d        = '1;
        bus_driven_d = 1'b0;
        if (any_force) begin
            bus_d        = resolved;
            bus_driven_d = 1'b1;
        end else if (state_q == StOwn) begin
            bus_d        = owner_data;
            bus_driven_d = 1'b1;
        end
    end

    // Saturating count of contention cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (contention_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Registered bus outputs and conflict tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q        <= '1;
            bus_driven_q <= 1'b0;
            contention_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            bus_q        <= bus_d;
            bus_driven_q <= bus_driven_d;
            contention_q <= contention_d;
            cnt_q        <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign bus          = bus_q;
    assign bus_driven   = bus_driven_q;
    assign contention   = contention_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/shared_bus_resolver.md
# shared_bus_resolver

Parametrised, clocked resolver for a shared pulled-up bus with N drivers. Arbitrated drivers take the bus through a round-robin, burst-holding grant. Forced drivers bypass the arbiter, and when they disagree the bus value is resolved by a wired-AND or wired-OR rule and the conflict is flagged and counted. The block is the registered, synthesizable successor of the team's tri1 multi-driver net: an idle bus reads all-ones, and a driver conflict gives a defined value instead of X.

## Interface
- WIDTH, 8: bus data width in bits (≥1).
- N, 4: number of drivers/channels (2..16).
- RESOLVE, 0: conflict rule; 0 = wired-AND, 1 = wired-OR.
- CNT_W, 8: width of the conflict counter.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-channel bus request (arbitrated path).
- last  in  N  per-channel end-of-burst; sampled only for the granted channel.
- wdata  in  N*WIDTH  per-channel drive value; channel i occupies bits [i*WIDTH +: WIDTH].
- force_en  in  N  per-channel unarbitrated drive enable (bypass path).
- grant  out  N  registered one-hot grant; all zero when idle.
- bus  out  WIDTH  registered resolved bus value.
- bus_driven  out  1  registered; 1 when some driver (granted or forced) set bus this cycle.
- contention  out  1  registered; 1 when forced drivers disagreed in the previous cycle.
- conflict_cnt  out  CNT_W  number of contention cycles, saturating.

## Operation
- Arbiter FSM, two states:
  - IDLE: grant=0.
  - OWN: exactly one grant bit set.
- IDLE → OWN when any req=1 and force_en=0.
  - Winner is the first requesting channel found scanning upward (with wrap) from last_owner+1.
  - last_owner resets to N-1, so channel 0 has first priority after reset.
- OWN → IDLE when the granted channel has last=1 or req=0 at an edge with force_en=0. last_owner is updated to that channel.
- OWN never switches directly to another channel; at least one IDLE cycle separates owners.
- Grant is held, and the FSM frozen, in any cycle with force_en≠0. Forced drivers preempt the arbitrated path.
- Bus value (next) is chosen in this order:
  1. force_en≠0: combine wdata of all forced channels by AND (RESOLVE=0) or OR (RESOLVE=1). Set bus_driven=1.
  2. Else OWN: wdata of the granted channel. Set bus_driven=1.
  3. Else: all-ones pull-up. Set bus_driven=0.
- contention_next=1 when two or more forced channels are present and their wdata are not all identical. Agreeing forced drivers are not a conflict.
- conflict_cnt increments on each edge where contention_next=1 and saturates at 2^CNT_W-1.
- Arbitrated req from a channel that is also forcing is still honoured normally.

## Timing
- Reset values, asynchronous and immediate:
  - grant=0, FSM=IDLE, last_owner=N-1.
  - bus={WIDTH{1'b1}}, bus_driven=0, contention=0, conflict_cnt=0.
- Grant latency: req high before edge k → grant valid after edge k.
- Data latency: wdata presented while grant is high before edge k → bus after edge k. The first burst beat therefore appears 2 edges after req.
- Forced-drive latency: force_en/wdata before edge k → bus, bus_driven, contention after edge k (1 cycle).
- Release: the edge that samples last=1 still registers that beat's data, and grant drops after the same edge. If nothing else drives, bus returns to all-ones one edge later.
- Reset mid-burst: grant and bus return to reset values at once. After deassertion, arbitration restarts from channel 0 priority.

## Test plan
- Reset/idle: assert rst mid-run, then release with all inputs 0 → grant=0, bus=8'hFF, bus_driven=0, conflict_cnt=0.
- Single burst: req[2]=1 with wdata ch2=8'h11, 8'h22, 8'h33, last on the third beat → grant=4'b0100 after edge 1; bus 8'h11/8'h22/8'h33 on edges 2-4; grant=0 after edge 4; bus=8'hFF after edge 5.
- Round-robin fairness: req=4'b1111 held, single-beat bursts → owners 0,1,2,3,0 with one IDLE cycle between each.
- Conflict, RESOLVE=0: force_en=4'b0011, ch0=8'hF0, ch1=8'h3C for 3 cycles → bus=8'h30, contention=1, conflict_cnt=3.
- Conflict, RESOLVE=1, same stimulus → bus=8'hFC. Agreeing case (both 8'hA5) → bus=8'hA5, contention=0, count unchanged.
- Preemption and saturation, CNT_W=2:
  - force ch3 mid-burst of ch1 → grant stays 4'b0010, bus=ch3 data, burst resumes when force_en drops.
  - 5 conflicting cycles → conflict_cnt=3.
